// File: rtl/slow_clock_monitor_pkg.sv
// rtl/slow_clock_monitor_pkg.sv - shared types and defaults for the slow clock monitor
package slow_clk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } mon_state_e;

  localparam int HALF_PERIOD_DEF = 500;
  localparam int TOL_DEF         = 2;

  // Counter width that can hold the upper window edge plus headroom to saturate past it
  function automatic int cnt_width(input int half_period, input int tol);
    return $clog2(half_period + tol + 2);
  endfunction

endpackage

// File: rtl/slow_clock_monitor_if.sv
// rtl/slow_clock_monitor_if.sv - slow clock input, controls and monitor status bundle
interface slow_clock_monitor_if #(
  parameter int CW = slow_clk_pkg::cnt_width(slow_clk_pkg::HALF_PERIOD_DEF, slow_clk_pkg::TOL_DEF)
) ();

  logic          slow_clk_in;
  logic          enable;
  logic          clear_err;
  logic          rise_tick;
  logic          fall_tick;
  logic          locked;
  logic          period_err;
  logic [7:0]    err_count;
  logic [CW-1:0] last_half;

  // Consumer side: drives the slow clock and controls, observes status
  modport master (
    output slow_clk_in, enable, clear_err,
    input  rise_tick, fall_tick, locked, period_err, err_count, last_half
  );

  // Monitor side
  modport slave (
    input  slow_clk_in, enable, clear_err,
    output rise_tick, fall_tick, locked, period_err, err_count, last_half
  );

endinterface

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchronizer with registered rise/fall pulses
module sync_edge_det (
  input  logic clk_in,
  input  logic reset,
  input  logic async_in,
  output logic edge_det,
  output logic rise_tick,
  output logic fall_tick
);

  logic sync1;
  logic sync2;
  logic hist;

  // Sync chain, history flop, and one-cycle edge pulses registered off stage 2 vs history
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      hist      <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      sync1     <= async_in;
      sync2     <= sync1;
      hist      <= sync2;
      rise_tick <= sync2 & ~hist;
      fall_tick <= ~sync2 & hist;
    end
  end

  // Combinational edge flag so the consumer can register its reaction alongside the ticks
  assign edge_det = sync2 ^ hist;

endmodule

// File: rtl/slow_clock_monitor.sv
// rtl/slow_clock_monitor.sv - measures slow clock half-periods and tracks lock/fault
module slow_clock_monitor
  import slow_clk_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEF,
  parameter int TOL         = TOL_DEF,
  parameter int CW          = cnt_width(HALF_PERIOD, TOL)
) (
  input logic           clk_in,
  input logic           reset,
  slow_clock_monitor_if.slave mon
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] WIN_LO  = CW'(HALF_PERIOD - TOL);
  localparam logic [CW-1:0] WIN_HI  = CW'(HALF_PERIOD + TOL);

  mon_state_e    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] meas;
  logic          edge_seen;
  logic          in_win;
  logic          timeout;
  logic          fault;

  sync_edge_det u_sync (
    .clk_in    (clk_in),
    .reset     (reset),
    .async_in  (mon.slow_clk_in),
    .edge_det  (edge_seen),
    .rise_tick (mon.rise_tick),
    .fall_tick (mon.fall_tick)
  );

  // Interval is cnt+1 because cnt restarts at 0 in the cycle after the edge; a saturated
  // counter reports all-ones rather than wrapping
  assign meas    = (cnt == CNT_MAX) ? CNT_MAX : cnt + CW'(1);
  assign in_win  = (meas >= WIN_LO) && (meas <= WIN_HI);
  // cnt passes WIN_HI exactly once per interval since it saturates above it
  assign timeout = !edge_seen && (cnt == WIN_HI);
  assign fault   = mon.enable && (state == LOCKED) && (edge_seen ? !in_win : timeout);

  // Interval counter: restart on every edge, saturate while the slow clock is stalled
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (edge_seen) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Lock state machine with registered status, error pulse and saturating error count
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      mon.locked     <= 1'b0;
      mon.period_err <= 1'b0;
      mon.err_count  <= 8'd0;
      mon.last_half  <= '0;
    end else begin
      mon.period_err <= fault;

      if (mon.clear_err) begin
        mon.err_count <= 8'd0;
      end else if (fault && (mon.err_count != 8'hFF)) begin
        mon.err_count <= mon.err_count + 8'd1;
      end

      if (!mon.enable) begin
        state      <= IDLE;
        mon.locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (edge_seen) state <= ACQUIRE;
          end
          ACQUIRE: begin
            if (edge_seen) begin
              mon.last_half <= meas;
              if (in_win) begin
                state      <= LOCKED;
                mon.locked <= 1'b1;
              end
            end else if (timeout) begin
              state <= IDLE;
            end
          end
          LOCKED: begin
            if (edge_seen) mon.last_half <= meas;
            if (fault) begin
              state      <= FAULT;
              mon.locked <= 1'b0;
            end
          end
          FAULT: begin
            if (edge_seen) begin
              mon.last_half <= meas;
              state         <= ACQUIRE;
            end
          end
          default: begin
            state      <= IDLE;
            mon.locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/slow_clock_monitor.md
# slow_clock_monitor

Fast-domain checker for the divided quiz clock. It synchronizes the toggling `slow_clk` back into the `clk_in` domain and emits single-cycle rise/fall ticks for the quiz timer and display logic. It also measures every half-period and declares lock or fault against the nominal divider setting. It sits at the receiving end of the clock divider and is the only path by which fast-domain logic consumes the slow clock.

## Interface
- `HALF_PERIOD`, 500: nominal `clk_in` cycles between `slow_clk` toggles.
- `TOL`, 2: accepted deviation in cycles; the window is [HALF_PERIOD-TOL, HALF_PERIOD+TOL].
- `CW`, $clog2(HALF_PERIOD+TOL+2): width of the interval counter and `last_half`.
- `clk_in`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `slow_clk_in`  in  1  divided clock, treated as asynchronous.
- `enable`  in  1  monitoring enable.
- `clear_err`  in  1  synchronous clear of `err_count`.
- `rise_tick`  out  1  one-cycle pulse per synchronized rising edge.
- `fall_tick`  out  1  one-cycle pulse per synchronized falling edge.
- `locked`  out  1  last interval was in window; no fault since.
- `period_err`  out  1  one-cycle pulse on a fault.
- `err_count`  out  8  saturating fault count.
- `last_half`  out  CW  most recent measured interval.

## Operation
- Synchronizer: 2-FF chain followed by a history flop. An edge is detected when sync stage 2 differs from the history flop. Ticks are registered and fire regardless of `enable`.
- Interval counter `cnt`:
  - Cleared on the edge cycle; increments otherwise; saturates at all-ones.
  - Measured interval = `cnt`+1, so ideal 500-cycle toggling measures exactly 500.
- FSM states: IDLE, ACQUIRE, LOCKED, FAULT.
  - IDLE: on an edge with `enable`=1, go to ACQUIRE.
  - ACQUIRE:
    - Edge with in-window measurement: go to LOCKED.
    - Edge with out-of-window measurement: stay in ACQUIRE; the measurement restarts.
    - Timeout: go to IDLE.
    - No error is flagged in ACQUIRE.
  - LOCKED: an out-of-window edge or a timeout goes to FAULT, pulses `period_err`, and increments `err_count`.
  - FAULT: on the next edge, go to ACQUIRE.
- Timeout: `cnt` == HALF_PERIOD+TOL with no edge in that cycle. It is evaluated once per interval; `cnt` keeps counting and saturating afterwards.
- Simultaneous edge and timeout: the edge wins, and at most one error is counted.
- `locked` = 1 only in LOCKED.
- `last_half` updates with the measured interval on every edge while not in IDLE. Otherwise it holds.
- `enable`=0 forces IDLE from any state. `err_count` and `last_half` hold.
- `err_count` saturates at 255. If `clear_err` coincides with an increment, the clear wins and the result is 0.

## Timing
- Reset values: all outputs 0, state IDLE, `cnt` 0, sync flops 0.
- Tick latency: `rise_tick`/`fall_tick` are high during the cycle after the 3rd `clk_in` edge that samples the new input level. The pulse is exactly one cycle wide.
- `locked`, `period_err`, `err_count` and `last_half` update on the same clock edge that raises the corresponding tick. For a timeout, they update on the edge following the cycle where `cnt` == HALF_PERIOD+TOL.
- Reset mid-operation clears everything immediately. The next edge after reset release restarts acquisition from IDLE.
- The first post-reset edge may be spurious if `slow_clk_in` is already 1. It is treated as a normal edge (IDLE→ACQUIRE).

## Structure
- Package `slow_clk_pkg`: state enum (IDLE/ACQUIRE/LOCKED/FAULT) and default constants HALF_PERIOD_DEF=500 and TOL_DEF=2.
- Sub-module `sync_edge_det`: 2-FF synchronizer, history flop, and registered rise/fall pulses. It is reused for the quiz button inputs.
- The top level holds the counter, FSM and error logic.

## Test plan
- Toggle `slow_clk_in` every 500 cycles, `enable`=1:
  - 1st edge → ACQUIRE; 2nd edge → `locked`=1 and `last_half`=500.
  - Ticks alternate rise/fall.
  - `err_count` stays 0 over 20 edges.
- Intervals 498 then 502 while LOCKED: lock holds, with no errors. An interval of 497: `period_err` pulses once, `err_count`=1, `locked`=0. Next edge → ACQUIRE; next 500-cycle interval → LOCKED.
- Stop toggling while LOCKED:
  - `period_err` pulses exactly once, 503 cycles after the last edge (`cnt`==502).
  - `err_count` increments once.
  - No further errors while stalled.
- Drive `err_count` to 255 with repeated faults: it stays at 255. Assert `clear_err` in the same cycle as a fault → `err_count`=0.
- Assert `reset` mid-LOCKED for one cycle: all outputs read 0 immediately. Resuming 500-cycle toggling relocks after the 2nd post-reset edge.
- Deassert `enable` while LOCKED:
  - `locked`=0 next cycle.
  - Ticks continue.
  - `last_half` and `err_count` hold.
  - After re-enable, the first edge → ACQUIRE.
